// File: rtl/reg_dump_if.sv
// reg_dump_if: beat stream carrying one (index, data) pair per register.
// Latency: none. This is a bundle of wires only.
// Backpressure: a beat moves on out_valid && out_ready, and the master holds
//    the payload stable until that happens.
// Signals: out_valid/out_data/out_index/out_last go from the master to the
//    slave. out_ready goes from the slave to the master.
interface reg_dump_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_index;
   logic              out_last;

   modport master (
      output out_valid,
      output out_data,
      output out_index,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_index,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/reg_dump.sv
// reg_dump: walks a wrapping register range on the spare RF read port and
//    streams each value out as an (index, data) beat.
// Latency: the first beat is valid 2 cycles after start. With no stalls,
//    one beat goes out every 2 cycles.
// Backpressure: SEND waits for out_ready with the payload held stable. Each
//    stalled cycle delays everything after it by one cycle.
// Ports:
//    clk, rst                      clock, synchronous active-high reset
//    start, first_addr, last_addr  dump request (sampled only in IDLE)
//    rf_addr, rf_data              asynchronous register-file read port
//    beat                          beat stream (valid/ready, master side)
//    busy, done                    busy = not IDLE; done = 1-cycle end pulse
module reg_dump #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] first_addr,
   input  logic [ADDR_W-1:0] last_addr,
   output logic [ADDR_W-1:0] rf_addr,
   input  logic [DATA_W-1:0] rf_data,
   reg_dump_if.master        beat,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [ADDR_W-1:0] idx;        // register currently being read or sent
   logic [ADDR_W-1:0] end_addr;   // last register of this dump
   logic [DATA_W-1:0] data_q;
   logic [ADDR_W-1:0] index_q;
   logic              last_q;

   // Per-cycle controls decoded from the state.
   logic              load;       // latch the bounds for a new dump
   logic              capture;    // sample rf_data into the beat registers
   logic              advance;    // step to the next register
   logic              valid_c;
   logic              busy_c;
   logic              done_c;
   logic [ADDR_W-1:0] rf_addr_c;
   logic              hs;

   assign hs = beat.out_valid && beat.out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      capture   = 1'b0;
      advance   = 1'b0;
      valid_c   = 1'b0;
      busy_c    = 1'b1;
      done_c    = 1'b0;
      rf_addr_c = '0;

      case (state)
         IDLE: begin
            busy_c = 1'b0;
            if (start) begin
               load      = 1'b1;
               state_nxt = READ;
            end
         end
         READ: begin
            // rf_data is asynchronous, so it is captured in this same cycle.
            // A write-back that lands before this cycle is therefore seen.
            rf_addr_c = idx;
            capture   = 1'b1;
            state_nxt = SEND;
         end
         SEND: begin
            rf_addr_c = idx;
            valid_c   = 1'b1;
            if (hs) begin
               if (last_q) begin
                  state_nxt = DONE;
               end else begin
                  advance   = 1'b1;
                  state_nxt = READ;
               end
            end
         end
         DONE: begin
            done_c    = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath. Reset clears the payload too, so the beat that was pending
   // when reset hit is gone and not just hidden.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx      <= '0;
         end_addr <= '0;
         data_q   <= '0;
         index_q  <= '0;
         last_q   <= 1'b0;
      end else begin
         if (load) begin
            idx      <= first_addr;
            end_addr <= last_addr;
         end else if (advance) begin
            // Modulo-2^ADDR_W increment: the top index wraps to x0.
            idx <= idx + ADDR_W'(1);
         end
         if (capture) begin
            data_q  <= rf_data;
            index_q <= idx;
            last_q  <= (idx == end_addr);
         end
      end
   end

   assign beat.out_valid = valid_c;
   assign beat.out_data  = data_q;
   assign beat.out_index = index_q;
   assign beat.out_last  = last_q;
   assign rf_addr        = rf_addr_c;
   assign busy           = busy_c;
   assign done           = done_c;

endmodule

// File: tb/tb_reg_dump.sv
// tb_reg_dump: directed bench for reg_dump, with a behavioural register file
// that has one synchronous write-back port and an asynchronous read port.
module tb_reg_dump;

   logic        clk;
   logic        rst;
   logic        start;
   logic [4:0]  first_addr;
   logic [4:0]  last_addr;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data;
   logic        busy;
   logic        done;

   // Write-back port of the register-file model.
   logic        we;
   logic [4:0]  wa;
   logic [31:0] wd;
   logic [31:0] rf [32];

   int checks   = 0;
   int failures = 0;
   int rel      = 0;     // cycles since the edge that sampled start
   int done_rel = -1;

   int          idx_q [$];
   logic [31:0] dat_q [$];
   logic        lst_q [$];

   reg_dump_if #(.DATA_W(32), .ADDR_W(5)) bus ();

   reg_dump #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .first_addr (first_addr),
      .last_addr  (last_addr),
      .rf_addr    (rf_addr),
      .rf_data    (rf_data),
      .beat       (bus.master),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (we) rf[wa] <= wd;
   end
   assign rf_data = rf[rf_addr];

   task automatic tick();
      @(posedge clk);
      #1;
      rel++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      we = 1'b1; wa = a; wd = d;
      tick();
      we = 1'b0;
   endtask

   // Pulse start for one edge. After the call, the DUT is in READ and rel is 1.
   // The bounds are scrambled right afterwards, because the DUT must no longer
   // be looking at them.
   task automatic do_start(input logic [4:0] f, input logic [4:0] l);
      start = 1'b1; first_addr = f; last_addr = l;
      tick();
      rel = 1;
      start = 1'b0; first_addr = ~f; last_addr = ~l;
   endtask

   // Record beats until done, optionally injecting one start pulse and up to
   // two write-backs at given rel cycles. A write set up in cycle r is visible
   // from cycle r+1.
   task automatic collect(input int inj_rel,
                          input int w1_rel, input logic [4:0] w1_a, input logic [31:0] w1_d,
                          input int w2_rel, input logic [4:0] w2_a, input logic [31:0] w2_d);
      idx_q.delete(); dat_q.delete(); lst_q.delete();
      done_rel = -1;
      for (int n = 0; n < 300 && done_rel < 0; n++) begin
         start = (rel == inj_rel);
         first_addr = 5'd0; last_addr = 5'd31;
         we = 1'b0;
         if (rel == w1_rel) begin we = 1'b1; wa = w1_a; wd = w1_d; end
         if (rel == w2_rel) begin we = 1'b1; wa = w2_a; wd = w2_d; end
         if (bus.out_valid && bus.out_ready) begin
            idx_q.push_back(int'(bus.out_index));
            dat_q.push_back(bus.out_data);
            lst_q.push_back(bus.out_last);
         end
         if (done) done_rel = rel;
         else tick();
      end
      start = 1'b0; we = 1'b0;
      chk("done_seen", done_rel >= 0, 1'b1);
   endtask

   initial begin
      logic found;
      rst = 1'b1; start = 1'b0; first_addr = '0; last_addr = '0;
      we = 1'b0; wa = '0; wd = '0;
      bus.out_ready = 1'b1;

      // Preload xk = 0x1000_0000 + k while the DUT is held in reset.
      for (int k = 0; k < 32; k++) wr(5'(k), 32'h1000_0000 + 32'(k));

      // Reset wins over start in the same cycle.
      start = 1'b1; first_addr = 5'd3; last_addr = 5'd4;
      tick();
      start = 1'b0;
      chk("rst_busy",   busy, 1'b0);
      chk("rst_valid",  bus.out_valid, 1'b0);
      chk("rst_done",   done, 1'b0);
      chk("rst_last",   bus.out_last, 1'b0);
      chk("rst_data",   bus.out_data, 32'h0);
      chk("rst_index",  bus.out_index, 5'd0);
      chk("rst_rfaddr", rf_addr, 5'd0);
      rst = 1'b0;
      tick();
      chk("idle_after_rst", busy, 1'b0);

      // Full dump 0..31 with out_ready held high.
      do_start(5'd0, 5'd31);
      chk("full_read_busy", busy, 1'b1);
      chk("full_read_rfaddr", rf_addr, 5'd0);
      chk("full_read_valid", bus.out_valid, 1'b0);
      tick();
      chk("full_valid_e2", bus.out_valid, 1'b1);
      collect(-1, -1, 5'd0, 32'h0, -1, 5'd0, 32'h0);
      chk("full_count", idx_q.size(), 32'd32);
      for (int i = 0; i < 32 && i < idx_q.size(); i++) begin
         chk($sformatf("full_idx%0d", i),  idx_q[i], i);
         chk($sformatf("full_dat%0d", i),  dat_q[i], 32'h1000_0000 + 32'(i));
         chk($sformatf("full_last%0d", i), lst_q[i], (i == 31) ? 1'b1 : 1'b0);
      end
      chk("full_done_cycle", done_rel, 65);
      tick();
      chk("full_busy_low", busy, 1'b0);
      chk("full_rfaddr_idle", rf_addr, 5'd0);

      // Wrap 30 -> 1, started in the first IDLE cycle after DONE.
      do_start(5'd30, 5'd1);
      chk("wrap_accepted", busy, 1'b1);
      collect(-1, -1, 5'd0, 32'h0, -1, 5'd0, 32'h0);
      chk("wrap_count", idx_q.size(), 32'd4);
      if (idx_q.size() == 4) begin
         chk("wrap_idx0", idx_q[0], 30);
         chk("wrap_idx1", idx_q[1], 31);
         chk("wrap_idx2", idx_q[2], 0);
         chk("wrap_idx3", idx_q[3], 1);
         chk("wrap_x0",   dat_q[2], 32'h1000_0000);
         chk("wrap_last2", lst_q[2], 1'b0);
         chk("wrap_last3", lst_q[3], 1'b1);
      end
      chk("wrap_done_cycle", done_rel, 9);
      tick();

      // Single beat under back-pressure: out_ready low for 7 SEND cycles.
      wr(5'd5, 32'h5);
      bus.out_ready = 1'b0;
      do_start(5'd5, 5'd5);
      chk("bp_read_valid", bus.out_valid, 1'b0);
      tick();
      for (int i = 0; i < 7; i++) begin
         chk($sformatf("bp_valid%0d", i), bus.out_valid, 1'b1);
         chk($sformatf("bp_data%0d", i),  bus.out_data, 32'h5);
         chk($sformatf("bp_last%0d", i),  bus.out_last, 1'b1);
         chk($sformatf("bp_nodone%0d", i), done, 1'b0);
         tick();
      end
      bus.out_ready = 1'b1;
      chk("bp_valid7", bus.out_valid, 1'b1);
      chk("bp_index", bus.out_index, 5'd5);
      tick();
      chk("bp_done", done, 1'b1);
      chk("bp_valid_after", bus.out_valid, 1'b0);
      chk("bp_done_cycle", rel, 10);
      tick();
      chk("bp_done_pulse", done, 1'b0);
      chk("bp_busy_low", busy, 1'b0);

      // Live reads: x3 written just before its READ, x2 just after its capture.
      do_start(5'd0, 5'd4);
      collect(-1, 6, 5'd3, 32'hDEAD, 7, 5'd2, 32'hBEEF);
      chk("live_count", idx_q.size(), 32'd5);
      if (idx_q.size() == 5) begin
         chk("live_x2_old", dat_q[2], 32'h1000_0002);
         chk("live_x3_new", dat_q[3], 32'hDEAD);
         chk("live_x4",     dat_q[4], 32'h1000_0004);
      end
      tick();

      // Ignored start: a second start with other bounds arrives mid-dump.
      do_start(5'd8, 5'd11);
      collect(4, -1, 5'd0, 32'h0, -1, 5'd0, 32'h0);
      chk("ign_count", idx_q.size(), 32'd4);
      if (idx_q.size() == 4) begin
         chk("ign_idx0", idx_q[0], 8);
         chk("ign_idx3", idx_q[3], 11);
      end
      chk("ign_done_cycle", done_rel, 9);
      tick();
      chk("ign_idle", busy, 1'b0);

      // Reset in SEND on index 7 with a pending beat.
      do_start(5'd4, 5'd10);
      found = 1'b0;
      for (int n = 0; n < 50 && !found; n++) begin
         if (bus.out_valid && bus.out_index == 5'd7) begin
            bus.out_ready = 1'b0;
            found = 1'b1;
         end else begin
            tick();
         end
      end
      chk("mid_found", found, 1'b1);
      chk("mid_rfaddr", rf_addr, 5'd7);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_valid", bus.out_valid, 1'b0);
      chk("mid_last",  bus.out_last, 1'b0);
      chk("mid_busy",  busy, 1'b0);
      chk("mid_done",  done, 1'b0);
      chk("mid_data",  bus.out_data, 32'h0);
      chk("mid_index", bus.out_index, 5'd0);
      chk("mid_rfaddr0", rf_addr, 5'd0);
      bus.out_ready = 1'b1;
      do_start(5'd20, 5'd21);
      collect(-1, -1, 5'd0, 32'h0, -1, 5'd0, 32'h0);
      chk("restart_count", idx_q.size(), 32'd2);
      if (idx_q.size() == 2) begin
         chk("restart_idx0", idx_q[0], 20);
         chk("restart_dat1", dat_q[1], 32'h1000_0015);
         chk("restart_last1", lst_q[1], 1'b1);
      end
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
